// File: rtl/button_debouncer.sv
// button_debouncer
// Synchronises and debounces raw push-button inputs. Each channel produces
// a clean level, one-cycle press/release/long-press pulses and a toggle bit
// that flips on every accepted press (handy for driving an LED directly).
//
// Per-channel state machine, encoded as {level, cnt != 0}:
//   state       | meaning
//   ------------+-----------------------------------------------------------
//   UP          | released and stable (level=0, cnt=0)
//   CHECK_DOWN  | released, synchronised input reads pressed, counting
//   DOWN        | pressed and stable (level=1, cnt=0)
//   CHECK_UP    | pressed, synchronised input reads released, counting
//
// A level change is accepted only after the synchronised input has
// differed from the current level for DEBOUNCE_CYCLES consecutive edges;
// any bounce back to the current level restarts the count.
module button_debouncer #(
    parameter int N_BTN           = 4,
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int LONG_CYCLES     = 25000000
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [N_BTN-1:0] i_sw,
    output logic [N_BTN-1:0] o_level,
    output logic [N_BTN-1:0] o_press,
    output logic [N_BTN-1:0] o_release,
    output logic [N_BTN-1:0] o_long_press,
    output logic [N_BTN-1:0] o_toggle
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam int HW = $clog2(LONG_CYCLES + 1);

    localparam logic [CW-1:0] CNT_LAST  = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_MAX  = HW'(LONG_CYCLES);
    localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CYCLES - 1);

    localparam logic [1:0] ST_UP         = 2'b00;
    localparam logic [1:0] ST_CHECK_DOWN = 2'b01;
    localparam logic [1:0] ST_DOWN       = 2'b10;
    localparam logic [1:0] ST_CHECK_UP   = 2'b11;

    logic [N_BTN-1:0] r_s1;
    logic [N_BTN-1:0] r_s;

    // Two-stage synchroniser; only r_s is used downstream.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_s1 <= '0;
            r_s  <= '0;
        end else begin
            r_s1 <= i_sw;
            r_s  <= r_s1;
        end
    end

    for (genvar g = 0; g < N_BTN; g++) begin : g_ch
        logic [CW-1:0] r_cnt;
        logic [HW-1:0] r_hold;
        logic          r_level;
        logic          r_press;
        logic          r_release;
        logic          r_long;
        logic          r_toggle;
        logic [1:0]    w_state;
        logic          w_differs;
        logic          w_expire;

        assign w_state   = {r_level, (r_cnt != '0)};
        assign w_differs = (r_s[g] != r_level);
        assign w_expire  = (r_cnt == CNT_LAST);

        // Debounce state machine; pulses and toggle are registered so they
        // appear in the same cycle as the new level.
        always_ff @(posedge i_clk) begin
            if (i_rst) begin
                r_cnt     <= '0;
                r_level   <= 1'b0;
                r_press   <= 1'b0;
                r_release <= 1'b0;
                r_toggle  <= 1'b0;
            end else begin
                r_press   <= 1'b0;
                r_release <= 1'b0;
                case (w_state)
                    ST_UP, ST_DOWN: begin
                        if (w_differs) begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                    ST_CHECK_DOWN, ST_CHECK_UP: begin
                        if (!w_differs) begin
                            r_cnt <= '0;
                        end else if (w_expire) begin
                            r_cnt   <= '0;
                            r_level <= r_s[g];
                            if (r_s[g]) begin
                                r_press  <= 1'b1;
                                r_toggle <= ~r_toggle;
                            end else begin
                                r_release <= 1'b1;
                            end
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                    default: begin
                        r_cnt <= '0;
                    end
                endcase
            end
        end

        // Hold timer: runs while the debounced level is high, saturates at
        // LONG_CYCLES and fires the long-press pulse once on reaching it.
        // Bounce inside CHECK_UP leaves level high, so the count survives.
        always_ff @(posedge i_clk) begin
            if (i_rst || !r_level) begin
                r_hold <= '0;
                r_long <= 1'b0;
            end else begin
                r_long <= (r_hold == HOLD_LAST);
                if (r_hold != HOLD_MAX) begin
                    r_hold <= r_hold + 1'b1;
                end
            end
        end

        assign o_level[g]      = r_level;
        assign o_press[g]      = r_press;
        assign o_release[g]    = r_release;
        assign o_long_press[g] = r_long;
        assign o_toggle[g]     = r_toggle;
    end

endmodule

// File: tb/tb_button_debouncer.sv
// Testbench for button_debouncer with small timing parameters.
module tb_button_debouncer;

    localparam int NB = 4;
    localparam int DC = 4;
    localparam int LC = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [NB-1:0] sw  = '0;
    logic [NB-1:0] level, press, rel, lp, tog;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    button_debouncer #(
        .N_BTN          (NB),
        .DEBOUNCE_CYCLES(DC),
        .LONG_CYCLES    (LC)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_sw        (sw),
        .o_level     (level),
        .o_press     (press),
        .o_release   (rel),
        .o_long_press(lp),
        .o_toggle    (tog)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    // Reference model: counts how long the synchronised input has disagreed
    // with the accepted level, and how long the level has been held high.
    logic [NB-1:0] m_s1 = '0, m_s = '0, m_level = '0;
    logic [NB-1:0] m_press = '0, m_rel = '0, m_long = '0, m_tog = '0;
    int  m_run  [NB];
    int  m_hold [NB];
    bit  model_on = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            model_on = 1'b1;
            m_s1 = '0; m_s = '0; m_level = '0;
            m_press = '0; m_rel = '0; m_long = '0; m_tog = '0;
            for (int i = 0; i < NB; i++) begin
                m_run[i]  = 0;
                m_hold[i] = 0;
            end
        end else begin
            for (int i = 0; i < NB; i++) begin
                m_press[i] = 1'b0;
                m_rel[i]   = 1'b0;
                m_long[i]  = 1'b0;
                if (m_level[i]) begin
                    if (m_hold[i] < LC) begin
                        m_hold[i]++;
                        if (m_hold[i] == LC) m_long[i] = 1'b1;
                    end
                end else begin
                    m_hold[i] = 0;
                end
                if (m_s[i] != m_level[i]) begin
                    m_run[i]++;
                    if (m_run[i] == DC) begin
                        m_level[i] = m_s[i];
                        m_run[i]   = 0;
                        if (m_s[i]) begin
                            m_press[i] = 1'b1;
                            m_tog[i]   = ~m_tog[i];
                        end else begin
                            m_rel[i] = 1'b1;
                        end
                    end
                end else begin
                    m_run[i] = 0;
                end
                m_s[i]  = m_s1[i];
                m_s1[i] = sw[i];
            end
        end
    end

    always @(negedge clk) begin
        if (model_on) begin
            check("model {level,press,release,long,toggle}",
                  {level, press, rel, lp, tog},
                  {m_level, m_press, m_rel, m_long, m_tog});
        end
    end

    // Drive inputs at a falling edge and wait until the next falling edge.
    task automatic step(input logic r, input logic [NB-1:0] v);
        rst = r;
        sw  = v;
        @(negedge clk);
    endtask

    typedef struct {
        logic          rst;
        logic [NB-1:0] sw;
        logic [NB-1:0] level;
        logic [NB-1:0] press;
        logic [NB-1:0] rel;
        logic [NB-1:0] lp;
        logic [NB-1:0] tog;
    } vec_t;

    vec_t vt [9];

    initial begin
        logic [NB-1:0] v;
        logic          bad;
        int            bseq [5];
        int            rise_k, long_k, long_cnt, rel_k;
        bit            slow;

        @(negedge clk);

        // Clean press on channel 0: entry 1 is edge 0, level rises on edge 5.
        vt[0] = '{1'b1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
        vt[1] = '{1'b0, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
        vt[2] = '{1'b0, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
        vt[3] = '{1'b0, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
        vt[4] = '{1'b0, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
        vt[5] = '{1'b0, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
        vt[6] = '{1'b0, 4'h1, 4'h1, 4'h1, 4'h0, 4'h0, 4'h1};
        vt[7] = '{1'b0, 4'h1, 4'h1, 4'h0, 4'h0, 4'h0, 4'h1};
        vt[8] = '{1'b0, 4'h1, 4'h1, 4'h0, 4'h0, 4'h0, 4'h1};
        for (int i = 0; i < 9; i++) begin
            step(vt[i].rst, vt[i].sw);
            check($sformatf("clean_press vec%0d", i), {level, press, rel, lp, tog},
                  {vt[i].level, vt[i].press, vt[i].rel, vt[i].lp, vt[i].tog});
        end

        // Bounce on channel 1: 1,1,1,0 then 1 held (final rise at k=4).
        step(1'b1, '0);
        bseq = '{1, 1, 1, 0, 1};
        bad  = 1'b0;
        for (int k = 0; k < 14; k++) begin
            v    = '0;
            v[1] = (k < 5) ? bseq[k][0] : 1'b1;
            step(1'b0, v);
            if (k < 9) bad = bad | level[1] | press[1] | rel[1];
            if (k == 9) check("bounce_rise {level,press}", {level[1], press[1]}, 2'b11);
        end
        check("bounce_quiet", {31'd0, bad}, 32'd0);

        // Glitch on channel 2: three cycles high, then low for a long time.
        step(1'b1, '0);
        bad = 1'b0;
        for (int k = 0; k < 40; k++) begin
            v    = '0;
            v[2] = (k < 3);
            step(1'b0, v);
            bad = bad | level[2] | press[2] | rel[2] | lp[2] | tog[2];
        end
        check("glitch_quiet", {31'd0, bad}, 32'd0);

        // Long press on channel 3, release, then a second press.
        step(1'b1, '0);
        rise_k = -1; long_k = -1; long_cnt = 0; rel_k = -1;
        for (int k = 0; k < 60; k++) begin
            v    = '0;
            v[3] = (k < 30) || (k >= 45);
            step(1'b0, v);
            if (k < 45) begin
                if (level[3] && rise_k < 0) rise_k = k;
                if (lp[3]) begin
                    long_cnt++;
                    long_k = k;
                end
                if (rel[3] && rel_k < 0) rel_k = k;
            end
            if (k == 10) check("toggle_after_first_press", {31'd0, tog[3]}, 32'd1);
        end
        check("long_rise_edge", rise_k, 5);
        check("long_pulse_count", long_cnt, 1);
        check("long_pulse_edge", long_k, 5 + LC);
        check("release_edge", rel_k, 30 + DC + 1);
        check("toggle_after_second_press", {31'd0, tog[3]}, 32'd0);

        // Simultaneous press on all channels.
        step(1'b1, '0);
        for (int k = 0; k < 6; k++) begin
            step(1'b0, 4'hF);
            if (k == 4) check("simul_before", {level, press}, 8'h00);
            if (k == 5) check("simul_press", {level, press}, 8'hFF);
        end
        for (int k = 0; k < 10; k++) step(1'b0, '0);
        check("simul_toggle", tog, 4'hF);

        // Reset while channel 0 is mid-debounce with the button held.
        for (int k = 0; k < 4; k++) step(1'b0, 4'h1);
        step(1'b1, 4'h1);
        check("reset_mid_outputs", {level, press, rel, lp, tog}, 20'h0);
        for (int k = 0; k < 7; k++) begin
            step(1'b0, 4'h1);
            if (k == 4) check("reset_recover_before", {level, press}, 8'h00);
            if (k == 5) check("reset_recover_press", {level, press}, 8'h11);
            if (k == 6) check("reset_recover_after", {level, press}, 8'h10);
        end

        // Random stimulus against the model, alternating fast and slow phases.
        v    = '0;
        slow = 1'b0;
        for (int k = 0; k < 4000; k++) begin
            if (k % 400 == 0) slow = ~slow;
            for (int b = 0; b < NB; b++) begin
                if ($urandom_range(0, slow ? 40 : 5) == 0) v[b] = ~v[b];
            end
            step(($urandom_range(0, 499) == 0), v);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/button_debouncer.md
Name: button_debouncer

Overview:
- Input-side counterpart to the board's LED drivers: samples the raw push-button inputs (SW1..SW4 on the 25 MHz board), synchronises and debounces each one, and produces clean levels and one-cycle press, release and long-press event pulses.
- Also keeps a per-button toggle bit that can drive an LED directly.
- Sits between the board pins and any user logic that reacts to buttons.

Parameters:
- N_BTN, 4, number of independent button channels.
- DEBOUNCE_CYCLES, 250000, number of consecutive stable cycles needed to accept a level change (10 ms at 25 MHz). Must be >= 2.
- LONG_CYCLES, 25000000, number of cycles the debounced level must stay high before the long-press pulse (1 s at 25 MHz). Must be > DEBOUNCE_CYCLES.

Ports:
- CLK  input  1  system clock, 25 MHz.
- RST  input  1  synchronous, active-high reset.
- SW  input  N_BTN  raw button inputs, asynchronous to CLK, 1 = pressed.
- level  output  N_BTN  debounced button state, 1 = pressed.
- press  output  N_BTN  one-cycle pulse on accepted 0->1 transition.
- release  output  N_BTN  one-cycle pulse on accepted 1->0 transition.
- long_press  output  N_BTN  one-cycle pulse when level has been high for LONG_CYCLES.
- toggle  output  N_BTN  flips on each press pulse; intended for LEDs.

Behaviour:
- Clocking and reset:
  - One clock, CLK. RST is synchronous and active-high, sampled on the CLK rising edge.
  - Reset clears all outputs, both synchroniser stages, and all counters to 0.
  - Reset asserted mid-debounce or mid-hold abandons that operation; no pulses are generated in the reset cycle.
- Channels: all channels are identical and fully independent. Each channel is described below for bit i.
- Synchroniser:
  - Two flip-flop stages: SW[i] -> s1 -> s.
  - Only s is used downstream.
- Debounce counter (width $clog2(DEBOUNCE_CYCLES)):
  - If s == level, the counter is cleared to 0 on that edge. Any bounce back therefore restarts the count.
  - If s != level and cnt < DEBOUNCE_CYCLES-1: cnt <= cnt+1.
  - If s != level and cnt == DEBOUNCE_CYCLES-1: level <= s and cnt <= 0.
- Latency:
  - Edge 0 is the first CLK edge that samples SW[i] changed, with SW[i] held stable from then on.
  - level changes on edge DEBOUNCE_CYCLES+1, i.e. DEBOUNCE_CYCLES+2 edges after edge 0.
- Per-channel state machine (states are encoded by level and cnt != 0):
  - UP: level=0, cnt=0.
  - CHECK_DOWN: level=0, cnt>0.
  - DOWN: level=1, cnt=0.
  - CHECK_UP: level=1, cnt>0.
  - Transitions: UP -> CHECK_DOWN when s=1; CHECK_DOWN -> UP when s=0; CHECK_DOWN -> DOWN on count expiry; DOWN and CHECK_UP are symmetric.
- Event pulses:
  - press[i] and release[i] are registered. Each is high for exactly the one cycle in which level[i] shows its new value (same cycle as the first new level).
  - No pulse is generated while in a CHECK state.
- Toggle: toggle[i] flips on the same edge that level rises, so it is visible together with press[i].
- Long-press hold counter (width $clog2(LONG_CYCLES+1)):
  - Cleared while level=0. Incremented while level=1, saturating at LONG_CYCLES.
  - long_press[i] pulses exactly once, on the edge where the hold counter goes from LONG_CYCLES-1 to LONG_CYCLES.
  - No repeat pulse while the button is still held. A new press starts a fresh hold count.
  - Bounce inside CHECK_UP does not clear the hold counter; only level falling does.
- Simultaneous events: any combination of channels may pulse in the same cycle.
- Boundary conditions:
  - A button held through reset release is treated as a new press: press fires DEBOUNCE_CYCLES+2 edges after reset deasserts.
  - A glitch shorter than DEBOUNCE_CYCLES cycles produces no level change and no pulses.

Test Plan (all scenarios use DEBOUNCE_CYCLES=4, LONG_CYCLES=16, N_BTN=4):
- Clean press:
  - Stimulus: after reset, SW=4'b0001 first sampled at edge 0 and held.
  - Required: level[0]=1 and press[0]=1 after edge 5 only; toggle[0]=1; press[0]=0 the following cycle; other bits stay 0.
- Bounce rejection:
  - Stimulus: SW[1] goes 1 for 3 cycles, 0 for 1 cycle, then 1 held.
  - Required: no pulse during the bounce; level[1] rises 6 edges after the final rising sample.
- Glitch:
  - Stimulus: SW[2]=1 for 3 cycles, then 0.
  - Required: level, press, release and toggle all stay 0 indefinitely.
- Long press and release:
  - Stimulus: SW[3] held 30 cycles, then released.
  - Required: long_press[3] is a single one-cycle pulse 16 cycles after level[3] rose; release[3] pulses 6 edges after SW[3] is first sampled 0; second press sets toggle[3] back to 0.
- Simultaneous presses and reset mid-debounce:
  - Stimulus 1: SW=4'b1111 together.
  - Required: all four press bits pulse in the same cycle.
  - Stimulus 2: RST asserted while cnt=2, SW held high.
  - Required: outputs read 0 after that edge; press recurs 6 edges after RST deasserts.
